// File: rtl/ring_sched_pkg.sv
// Shared types and helpers for the round-robin slot scheduler.
// Vectors are indexed [0:N-1]; helpers work on N_MAX-wide vectors so any N up to N_MAX fits.
package ring_sched_pkg;

  localparam int N_DEF        = 8;
  localparam int MAX_HOLD_DEF = 16;
  localparam int N_MAX        = 32;
  localparam int IDX_W        = $clog2(N_MAX);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic logic [0:N_MAX-1] onehot(input logic [IDX_W-1:0] idx);
    logic [0:N_MAX-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First requester at or after the token position, wrapping at n.
  function automatic pick_t rr_pick(input logic [0:N_MAX-1] req,
                                    input logic [0:N_MAX-1] token,
                                    input int n);
    pick_t p;
    int    t;
    int    i;
    p = '0;
    t = 0;
    for (int k = N_MAX - 1; k >= 0; k--) begin
      if (k < n && token[IDX_W'(k)]) t = k;
    end
    for (int k = 0; k < N_MAX; k++) begin
      if (k < n) begin
        i = (t + k) % n;
        if (!p.vld && req[IDX_W'(i)]) begin
          p.vld = 1'b1;
          p.idx = IDX_W'(i);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ring_token.sv
// One-hot priority ring: init puts the token on bit 0, load overrides, advance rotates one place.
// Registered output, one cycle from load/advance to the new token.
module ring_token
  import ring_sched_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clock,
  input  logic         init,
  input  logic         load,
  input  logic [0:N-1] load_val,
  input  logic         advance,
  output logic [0:N-1] token
);

  logic [0:N-1] token_q, token_d;

  always_comb begin
    token_d = token_q;
    if (load) begin
      token_d = load_val;
    end else if (advance) begin
      token_d = {token_q[N-1], token_q[0:N-2]};
    end
  end

  always_ff @(posedge clock) begin
    if (init) begin
      token_q <= {1'b1, {(N-1){1'b0}}};
    end else begin
      token_q <= token_d;
    end
  end

  assign token = token_q;

endmodule

// File: rtl/ring_slot_scheduler.sv
// Round-robin owner of one shared resource; grant appears one cycle after req and is held until done,
// request drop or MAX_HOLD cycles, with one idle cycle between owners.
module ring_slot_scheduler
  import ring_sched_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clock,
  input  logic            init,
  input  logic [0:N-1]    req,
  input  logic            done,
  output logic [0:N-1]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic [0:N-1]    token,
  output logic            timeout
);

  localparam int HC_W = $clog2(MAX_HOLD);

  state_e            state_q, state_d;
  logic [0:N-1]      grant_q, grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic              tok_load;
  logic [0:N-1]      tok_val;
  logic [0:N_MAX-1]  req_full, tok_full, win_full, nxt_full;
  pick_t             pick;
  logic              own_req, at_limit;

  always_comb begin
    req_full        = '0;
    req_full[0:N-1] = req;
    tok_full        = '0;
    tok_full[0:N-1] = token;
    pick            = rr_pick(req_full, tok_full, N);
    win_full        = onehot(pick.idx);
    nxt_full        = onehot(IDX_W'((int'(grant_id_q) + 1) % N));
    own_req         = req[grant_id_q];
    at_limit        = (hold_cnt_q == HC_W'(MAX_HOLD - 1));

    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    tok_load   = 1'b0;
    tok_val    = nxt_full[0:N-1];

    case (state_q)
      IDLE: begin
        if (pick.vld) begin
          state_d    = BUSY;
          grant_d    = win_full[0:N-1];
          grant_id_d = ID_W'(pick.idx);
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      BUSY: begin
        if (done || !own_req || at_limit) begin
          state_d    = IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          // A voluntary release on the limit edge is not reported as a timeout.
          timeout_d  = at_limit && !done && own_req;
          tok_load   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (init) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  ring_token #(.N(N)) u_ring_token (
    .clock    (clock),
    .init     (init),
    .load     (tok_load),
    .load_val (tok_val),
    .advance  (1'b0),
    .token    (token)
  );

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_ring_slot_scheduler.sv
// Directed bench for ring_slot_scheduler with N=8, MAX_HOLD=16; index 0 is the leftmost bit.
module tb_ring_slot_scheduler;

  logic       clock = 1'b0;
  logic       init;
  logic [0:7] req;
  logic       done;
  logic [0:7] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic [0:7] token;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  ring_slot_scheduler #(.N(8), .MAX_HOLD(16), .ID_W(3)) dut (
    .clock    (clock),
    .init     (init),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .token    (token),
    .timeout  (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string name, input logic [0:7] g, input logic [2:0] id,
                             input logic b, input logic to, input logic [0:7] tk);
    n_cmp++;
    if (grant !== g || grant_id !== id || busy !== b || timeout !== to || token !== tk) begin
      n_err++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b timeout=%b token=%b, want grant=%b id=%0d busy=%b timeout=%b token=%b",
               name, grant, grant_id, busy, timeout, token, g, id, b, to, tk);
    end
  endtask

  task automatic do_reset();
    init = 1'b1;
    step();
    init = 1'b0;
  endtask

  task automatic test_reset();
    init = 1'b1; req = '0; done = 1'b0;
    step();
    step();
    if ({grant, grant_id, busy, timeout, token} !== {8'b0, 3'd0, 1'b0, 1'b0, 8'b1000_0000}) begin
      n_err++;
      $display("FAIL reset_state: got grant=%b id=%0d busy=%b timeout=%b token=%b, want 00000000 0 0 0 10000000",
               grant, grant_id, busy, timeout, token);
    end
    n_cmp++;
    init = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_state("reset_idle", 8'b0, 3'd0, 1'b0, 1'b0, 8'b1000_0000);
    end
  endtask

  task automatic test_single();
    req = 8'b0000_0100;
    step();
    check_state("single_grant", 8'b0000_0100, 3'd5, 1'b1, 1'b0, 8'b1000_0000);
    step();
    check_state("single_hold2", 8'b0000_0100, 3'd5, 1'b1, 1'b0, 8'b1000_0000);
    step();
    check_state("single_hold3", 8'b0000_0100, 3'd5, 1'b1, 1'b0, 8'b1000_0000);
    done = 1'b1;
    step();
    check_state("single_release", 8'b0, 3'd0, 1'b0, 1'b0, 8'b0000_0010);
    done = 1'b0;
    req  = '0;
    step();
    check_state("single_idle", 8'b0, 3'd0, 1'b0, 1'b0, 8'b0000_0010);
  endtask

  task automatic test_round_robin();
    logic [0:7] exp_g;
    logic [0:7] exp_t;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h80 >> (k % 8);
      exp_t = 8'h80 >> ((k + 1) % 8);
      step();
      check_state("rr_grant", exp_g, 3'(k % 8), 1'b1, 1'b0, exp_g);
      step();
      check_state("rr_hold", exp_g, 3'(k % 8), 1'b1, 1'b0, exp_g);
      done = 1'b1;
      step();
      check_state("rr_release", 8'b0, 3'd0, 1'b0, 1'b0, exp_t);
      done = 1'b0;
      if (k == 8) req = '0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'b0010_0000;
    step();
    check_state("to_grant", 8'b0010_0000, 3'd2, 1'b1, 1'b0, 8'b1000_0000);
    for (int c = 2; c <= 16; c++) begin
      step();
      check_state("to_hold", 8'b0010_0000, 3'd2, 1'b1, 1'b0, 8'b1000_0000);
    end
    step();
    check_state("to_release", 8'b0, 3'd0, 1'b0, 1'b1, 8'b0001_0000);
    step();
    check_state("to_regrant", 8'b0010_0000, 3'd2, 1'b1, 1'b0, 8'b0001_0000);
    for (int c = 2; c <= 16; c++) begin
      step();
      check_state("to_hold2", 8'b0010_0000, 3'd2, 1'b1, 1'b0, 8'b0001_0000);
    end
    done = 1'b1;
    step();
    check_state("to_done_on_limit", 8'b0, 3'd0, 1'b0, 1'b0, 8'b0001_0000);
    done = 1'b0;
    req  = '0;
    step();
    check_state("to_after", 8'b0, 3'd0, 1'b0, 1'b0, 8'b0001_0000);
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 8'b0000_0100;
    step();
    done = 1'b1;
    step();
    check_state("wd_token6", 8'b0, 3'd0, 1'b0, 1'b0, 8'b0000_0010);
    done = 1'b0;
    req  = 8'b1000_0001;
    step();
    check_state("wd_wrap_pick", 8'b0000_0001, 3'd7, 1'b1, 1'b0, 8'b0000_0010);
    req = 8'b1000_0000;
    step();
    check_state("wd_drop", 8'b0, 3'd0, 1'b0, 1'b0, 8'b1000_0000);
    step();
    check_state("wd_next", 8'b1000_0000, 3'd0, 1'b1, 1'b0, 8'b1000_0000);
    req = '0;
    step();
    check_state("wd_release", 8'b0, 3'd0, 1'b0, 1'b0, 8'b0100_0000);
  endtask

  task automatic test_reset_mid_grant();
    req = 8'b0001_0000;
    step();
    check_state("mid_grant3", 8'b0001_0000, 3'd3, 1'b1, 1'b0, 8'b0100_0000);
    step();
    req  = 8'b1001_0000;
    init = 1'b1;
    step();
    check_state("mid_init", 8'b0, 3'd0, 1'b0, 1'b0, 8'b1000_0000);
    init = 1'b0;
    step();
    check_state("mid_regrant0", 8'b1000_0000, 3'd0, 1'b1, 1'b0, 8'b1000_0000);
    req = '0;
    step();
  endtask

  initial begin
    init = 1'b1;
    req  = '0;
    done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_withdraw();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
